// File: rtl/store_stream_reader_if.sv
// Output stream bundle from store_stream_reader to the next layer.
// Ports: out_data/out_valid/out_last (master drives), out_ready (slave drives).
interface store_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/store_stream_reader.sv
// Streams NUM_VALS store values in index order over a valid/ready stream.
// Ports: clk, rst_n, start, busy, rd_sel/rd_data (store read side),
// str (stream master), done, max_val/max_idx/max_valid (argmax).
// Macro STORE_STREAM_READER_ARGMAX_EN builds the argmax tracker;
// without it the max_* outputs are tied to zero.
module store_stream_reader #(
    parameter int DATA_W   = 8,
    parameter int NUM_VALS = 10,
    parameter int SEL_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [SEL_W-1:0]  rd_sel,
    input  logic [DATA_W-1:0] rd_data,
    store_stream_reader_if.master str,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [SEL_W-1:0]  max_idx,
    output logic              max_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VALS - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // rd_data is captured here only; later store writes
                // do not disturb the element already in flight.
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = SEND;
            end
            SEND: begin
                if (str.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_sel        = (state_q == IDLE) ? '0 : idx_q;
    assign str.out_data  = out_data_q;
    assign str.out_valid = out_valid_q;
    assign str.out_last  = out_last_q;
    assign done          = done_q;
    assign busy          = busy_q;

`ifdef STORE_STREAM_READER_ARGMAX_EN
    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic [SEL_W-1:0]  max_idx_q, max_idx_d;
    logic              max_valid_q, max_valid_d;

    always_comb begin
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        max_valid_d = max_valid_q;
        if (state_q == IDLE && start) begin
            max_val_d   = '0;
            max_idx_d   = '0;
            max_valid_d = 1'b0;
        end else if (state_q == SEND && str.out_ready) begin
            // Strict compare: ties keep the earlier index.
            if (idx_q == '0 || out_data_q > max_val_q) begin
                max_val_d = out_data_q;
                max_idx_d = idx_q;
            end
            if (out_last_q) begin
                max_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val_q   <= '0;
            max_idx_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign max_val   = max_val_q;
    assign max_idx   = max_idx_q;
    assign max_valid = max_valid_q;
`else
    assign max_val   = '0;
    assign max_idx   = '0;
    assign max_valid = 1'b0;
`endif
endmodule

// File: tb/tb_store_stream_reader.sv
// Scoreboard bench for store_stream_reader: directed and random passes.
// Expected stream/argmax results come from a queue-based reference model.
module tb_store_stream_reader;
    localparam int N  = 10;
    localparam int DW = 8;
    localparam int SW = 32;
`ifdef STORE_STREAM_READER_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, max_valid;
    logic [SW-1:0] rd_sel, max_idx;
    logic [DW-1:0] rd_data, max_val;
    logic [DW-1:0] mem [N];

    int checks = 0;
    int errors = 0;

    store_stream_reader_if #(.DATA_W(DW)) bus ();

    store_stream_reader #(
        .DATA_W(DW), .NUM_VALS(N), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .rd_sel(rd_sel), .rd_data(rd_data), .str(bus),
        .done(done), .max_val(max_val), .max_idx(max_idx),
        .max_valid(max_valid)
    );

    always #5 clk = ~clk;

    assign rd_data = (rd_sel < SW'(N)) ? mem[rd_sel[3:0]] : '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    typedef struct { logic [DW-1:0] data; bit last; } exp_t;
    exp_t          expq[$];
    logic [DW-1:0] pass_vals[$];
    bit            model_busy = 0, pending_done = 0, prev_stall = 0;
    logic [DW-1:0] prev_data;
    bit            prev_last;
    int            cyc = 0, start_cyc = 0, stalls = 0;
    logic [DW-1:0] exp_mval = '0;
    int            exp_midx = 0;
    bit            exp_mvalid = 0;

    always @(negedge clk) begin
        bit   accept;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            model_busy   = 0;
            pending_done = 0;
            prev_stall   = 0;
            exp_mval     = '0;
            exp_midx     = 0;
            exp_mvalid   = 0;
        end else begin
            accept = start && !model_busy;
            if (done || pending_done) chk("done_pulse", done, pending_done);
            if (done && pending_done)
                chk("pass_cycles", cyc - start_cyc, 2 * N + 1 + stalls);
            pending_done = 0;
            chk("busy", busy, model_busy);
            chk("max_valid", max_valid, exp_mvalid);
            if (!model_busy) begin
                chk("max_val", max_val, exp_mval);
                chk("max_idx", max_idx, exp_midx);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_valid", bus.out_valid, 0);
                end else if (bus.out_ready) begin
                    e = expq.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                    if (e.last) begin
                        model_busy   = 0;
                        pending_done = 1;
                        if (ARGMAX) begin
                            exp_mval = pass_vals[0];
                            exp_midx = 0;
                            foreach (pass_vals[i])
                                if (pass_vals[i] > exp_mval) begin
                                    exp_mval = pass_vals[i];
                                    exp_midx = i;
                                end
                            exp_mvalid = 1;
                        end
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (prev_stall) stalls++;
            if (accept) begin
                model_busy = 1;
                start_cyc  = cyc;
                stalls     = 0;
                exp_mval   = '0;
                exp_midx   = 0;
                exp_mvalid = 0;
                pass_vals.delete();
                for (int i = 0; i < N; i++) begin
                    e.data = mem[i];
                    e.last = (i == N - 1);
                    expq.push_back(e);
                    pass_vals.push_back(mem[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_for(input int idx, input int limit);
        int n = 0;
        while (!(bus.out_valid && rd_sel == SW'(idx)) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("timeout_wait_elem", idx, -1);
    endtask

    task automatic wait_done(input int limit, input bit rnd);
        int n = 0;
        while (!done && n < limit) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        if (n >= limit) chk("timeout_done", 0, 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, bus.out_valid, 0);
        chk({nm, "_last"}, bus.out_last, 0);
        chk({nm, "_data"}, bus.out_data, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rdsel"}, rd_sel, 0);
        chk({nm, "_maxv"}, max_val, 0);
        chk({nm, "_maxi"}, max_idx, 0);
        chk({nm, "_maxok"}, max_valid, 0);
    endtask

    task automatic load_test_store();
        logic [DW-1:0] v [N] = '{8'd10, 8'd0, 8'd2, 8'd0, 8'd5,
                                 8'd0, 8'd0, 8'd12, 8'd0, 8'd13};
        foreach (v[i]) mem[i] = v[i];
    endtask

    initial begin
        bus.out_ready = 1'b1;
        load_test_store();
        #1;
        check_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Plain pass with ready held high.
        pulse_start();
        wait_done(100, 0);
        tick();

        // Three-cycle stall on element 4.
        pulse_start();
        wait_for(4, 40);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_elem4", bus.out_data, 5);
        end
        bus.out_ready = 1'b1;
        wait_done(100, 0);
        tick();

        // Store changes after capture must not reach out_data.
        pulse_start();
        wait_for(2, 40);
        bus.out_ready = 1'b0;
        mem[2] = 8'd72;
        tick();
        tick();
        chk("captured_elem2", bus.out_data, 2);
        bus.out_ready = 1'b1;
        wait_done(100, 0);
        mem[2] = 8'd2;
        tick();

        // Start mid-pass is ignored; start in done cycle is accepted.
        pulse_start();
        wait_for(3, 40);
        pulse_start();
        wait_done(100, 0);
        pulse_start();
        chk("restart_no_valid_yet", bus.out_valid, 0);
        tick();
        chk("restart_first_valid", bus.out_valid, 1);
        chk("restart_first_sel", rd_sel, 0);
        wait_done(100, 0);
        tick();

        // Reset while element 5 is valid, then a fresh pass.
        pulse_start();
        wait_for(5, 40);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        wait_done(100, 0);
        tick();

        // All-equal store: tie goes to index 0.
        foreach (mem[i]) mem[i] = 8'd7;
        pulse_start();
        wait_done(100, 0);
        tick();

        // Random stores with random back-pressure.
        for (int p = 0; p < 8; p++) begin
            foreach (mem[i]) mem[i] = 8'($urandom_range(0, (p % 2) ? 255 : 3));
            pulse_start();
            wait_done(400, 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
